// File: rtl/serial_comparer_if.sv
// Handshake bundle for serial_comparer: operand request channel and result channel.
interface serial_comparer_if #(
    parameter int WIDTH = 64
);
    logic             i_Valid;
    logic             o_Ready;
    logic [WIDTH-1:0] i_InputA;
    logic [WIDTH-1:0] i_InputB;
    logic             i_Unsigned;
    logic             o_Valid;
    logic             i_Ready;
    logic             o_EQ;
    logic             o_GT;
    logic             o_LT;

    // The comparer side.
    modport slave (
        input  i_Valid, i_InputA, i_InputB, i_Unsigned, i_Ready,
        output o_Ready, o_Valid, o_EQ, o_GT, o_LT
    );

    // The requester / consumer side.
    modport master (
        output i_Valid, i_InputA, i_InputB, i_Unsigned, i_Ready,
        input  o_Ready, o_Valid, o_EQ, o_GT, o_LT
    );
endinterface

// File: rtl/serial_comparer.sv
// Multi-cycle magnitude comparer: walks the operands CHUNK bits per cycle from
// the most significant chunk down and returns registered EQ/GT/LT flags.
module serial_comparer #(
    parameter int WIDTH      = 64,
    parameter int CHUNK      = 16,
    parameter int EARLY_EXIT = 1
) (
    input  logic             i_Clock,
    input  logic             i_Reset,
    serial_comparer_if.slave bus
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    generate
        if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_chunk
            $error("serial_comparer: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        RESULT  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             unsigned_q;
    logic [KW-1:0]    k_q;
    logic             found_q;
    logic             rec_gt_q;
    logic             rec_lt_q;
    logic             ready_q;
    logic             valid_q;
    logic             eq_q;
    logic             gt_q;
    logic             lt_q;

    logic [CHUNK-1:0]   chunk_a_d;
    logic [CHUNK-1:0]   chunk_b_d;
    logic               top_signed_d;
    logic signed [CHUNK:0] ext_a_d;
    logic signed [CHUNK:0] ext_b_d;
    logic               chunk_gt_d;
    logic               chunk_lt_d;
    logic               differ_d;
    logic               done_d;
    logic               res_gt_d;
    logic               res_lt_d;
    logic               accept_d;

    assign accept_d = (state_q == IDLE) && bus.i_Valid && ready_q;

    // Select chunk k, compare it (sign-extended only for the top chunk in signed
    // mode), and decide whether this cycle finishes the scan.
    always_comb begin
        chunk_a_d = a_q[CHUNK-1:0];
        chunk_b_d = b_q[CHUNK-1:0];
        for (int i = 1; i < N; i++) begin
            if (k_q == KW'(i)) begin
                chunk_a_d = a_q[i*CHUNK +: CHUNK];
                chunk_b_d = b_q[i*CHUNK +: CHUNK];
            end
        end
        top_signed_d = (k_q == KW'(N-1)) && !unsigned_q;
        ext_a_d      = {top_signed_d & chunk_a_d[CHUNK-1], chunk_a_d};
        ext_b_d      = {top_signed_d & chunk_b_d[CHUNK-1], chunk_b_d};
        chunk_gt_d   = (ext_a_d > ext_b_d);
        chunk_lt_d   = (ext_a_d < ext_b_d);
        differ_d     = chunk_gt_d | chunk_lt_d;
        done_d       = (k_q == '0) || ((EARLY_EXIT != 0) && differ_d);
        // The first differing chunk decides; a recorded one wins over the current.
        res_gt_d     = found_q ? rec_gt_q : chunk_gt_d;
        res_lt_d     = found_q ? rec_lt_q : chunk_lt_d;
    end

    // Operand capture on the accept edge only; later input changes are ignored.
    always_ff @(posedge i_Clock) begin
        if (accept_d) begin
            a_q        <= bus.i_InputA;
            b_q        <= bus.i_InputB;
            unsigned_q <= bus.i_Unsigned;
        end
    end

    // Control FSM with registered handshake and result flags.
    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            state_q  <= IDLE;
            k_q      <= '0;
            found_q  <= 1'b0;
            rec_gt_q <= 1'b0;
            rec_lt_q <= 1'b0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            eq_q     <= 1'b0;
            gt_q     <= 1'b0;
            lt_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        state_q <= COMPARE;
                        ready_q <= 1'b0;
                        k_q     <= KW'(N-1);
                        found_q <= 1'b0;
                    end
                end
                COMPARE: begin
                    if (done_d) begin
                        state_q <= RESULT;
                        valid_q <= 1'b1;
                        gt_q    <= res_gt_d;
                        lt_q    <= res_lt_d;
                        eq_q    <= !(res_gt_d || res_lt_d);
                    end else begin
                        k_q <= k_q - 1'b1;
                        if (differ_d && !found_q) begin
                            found_q  <= 1'b1;
                            rec_gt_q <= chunk_gt_d;
                            rec_lt_q <= chunk_lt_d;
                        end
                    end
                end
                RESULT: begin
                    if (bus.i_Ready) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        eq_q    <= 1'b0;
                        gt_q    <= 1'b0;
                        lt_q    <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_Ready = ready_q;
    assign bus.o_Valid = valid_q;
    assign bus.o_EQ    = eq_q;
    assign bus.o_GT    = gt_q;
    assign bus.o_LT    = lt_q;

endmodule

// File: tb/tb_serial_comparer.sv
// Directed bench for serial_comparer: early-exit 64/16, constant-latency 64/16
// and single-chunk 32/32 instances, checked against a queue of expected results.
module tb_serial_comparer;

    localparam logic [2:0] F_EQ = 3'b100;
    localparam logic [2:0] F_GT = 3'b010;
    localparam logic [2:0] F_LT = 3'b001;

    typedef struct {
        logic [2:0] flags;
        int         lat;
        string      tag;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    exp_t sb[$];

    serial_comparer_if #(.WIDTH(64)) if0 ();
    serial_comparer_if #(.WIDTH(64)) if1 ();
    serial_comparer_if #(.WIDTH(32)) if2 ();

    serial_comparer #(.WIDTH(64), .CHUNK(16), .EARLY_EXIT(1)) dut0 (
        .i_Clock(clk), .i_Reset(rst_n), .bus(if0.slave));
    serial_comparer #(.WIDTH(64), .CHUNK(16), .EARLY_EXIT(0)) dut1 (
        .i_Clock(clk), .i_Reset(rst_n), .bus(if1.slave));
    serial_comparer #(.WIDTH(32), .CHUNK(32), .EARLY_EXIT(1)) dut2 (
        .i_Clock(clk), .i_Reset(rst_n), .bus(if2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {valid, ready, eq, gt, lt}
    function automatic logic [4:0] outs(input int inst);
        case (inst)
            0:       return {if0.o_Valid, if0.o_Ready, if0.o_EQ, if0.o_GT, if0.o_LT};
            1:       return {if1.o_Valid, if1.o_Ready, if1.o_EQ, if1.o_GT, if1.o_LT};
            default: return {if2.o_Valid, if2.o_Ready, if2.o_EQ, if2.o_GT, if2.o_LT};
        endcase
    endfunction

    task automatic drive(input int inst, input logic v, input logic [63:0] a,
                         input logic [63:0] b, input logic uns);
        case (inst)
            0: begin if0.i_Valid = v; if0.i_InputA = a; if0.i_InputB = b; if0.i_Unsigned = uns; end
            1: begin if1.i_Valid = v; if1.i_InputA = a; if1.i_InputB = b; if1.i_Unsigned = uns; end
            default: begin
                if2.i_Valid = v; if2.i_InputA = a[31:0]; if2.i_InputB = b[31:0]; if2.i_Unsigned = uns;
            end
        endcase
    endtask

    task automatic set_rdy(input int inst, input logic r);
        case (inst)
            0:       if0.i_Ready = r;
            1:       if1.i_Ready = r;
            default: if2.i_Ready = r;
        endcase
    endtask

    // Entered at a negedge; leaves at the negedge right after the accept edge.
    task automatic issue(input int inst, input string tag, input logic [63:0] a,
                         input logic [63:0] b, input logic uns,
                         input logic [2:0] flags, input int lat);
        exp_t e;
        check({tag, ".rdy"}, 64'(outs(inst)[3]), 64'd1);
        drive(inst, 1'b1, a, b, uns);
        e.flags = flags; e.lat = lat; e.tag = tag;
        sb.push_back(e);
        @(negedge clk);
        // Scramble operands while busy; they must not affect the result.
        drive(inst, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
        check({tag, ".busy"}, 64'(outs(inst)[4:3]), 64'b00);
    endtask

    // Counts edges until o_Valid is seen, then compares latency and flags.
    task automatic wait_result(input int inst);
        exp_t        e;
        int          c;
        logic [4:0]  o;
        e = sb.pop_front();
        c = 0;
        o = outs(inst);
        while (!o[4] && c < 20) begin
            @(negedge clk);
            c++;
            o = outs(inst);
        end
        check({e.tag, ".lat"}, 64'(c), 64'(e.lat));
        check({e.tag, ".flags"}, 64'(o[2:0]), 64'(e.flags));
    endtask

    // With i_Ready high the result lasts one cycle and o_Ready returns.
    task automatic consume(input int inst, input string tag);
        @(negedge clk);
        check({tag, ".done"}, 64'(outs(inst)), 64'b01000);
    endtask

    task automatic run(input int inst, input string tag, input logic [63:0] a,
                       input logic [63:0] b, input logic uns,
                       input logic [2:0] flags, input int lat);
        issue(inst, tag, a, b, uns, flags, lat);
        wait_result(inst);
        consume(inst, tag);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(i, 1'b0, 64'd0, 64'd0, 1'b0);
            set_rdy(i, 1'b1);
        end
        #12;
        for (int i = 0; i < 3; i++)
            check($sformatf("reset%0d.outs", i), 64'({outs(i)[4], outs(i)[2:0]}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++)
            check($sformatf("reset%0d.idle", i), 64'(outs(i)), 64'b01000);

        // Early-exit instance, 4 chunks.
        run(0, "eq",      64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, F_EQ, 4);
        run(0, "m1_s",    64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, F_LT, 1);
        run(0, "m1_u",    64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1, F_GT, 1);
        run(0, "min_s",   64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, F_LT, 1);
        run(0, "c0_u",    64'h2, 64'h1, 1'b1, F_GT, 4);
        run(0, "c2",      64'h0000_0005_0000_0000, 64'h0000_0003_0000_0000, 1'b1, F_GT, 2);
        run(0, "lo_s",    64'h0000_0000_0000_8000, 64'h0, 1'b0, F_GT, 4);
        run(0, "neg_s",   64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, F_LT, 4);
        run(0, "mix",     64'h0002_0000_0000_0000, 64'h0001_0000_0000_FFFF, 1'b1, F_GT, 1);

        // Constant-latency instance.
        run(1, "x.m1_s",  64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, F_LT, 4);
        run(1, "x.m1_u",  64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1, F_GT, 4);
        run(1, "x.min_s", 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, F_LT, 4);
        run(1, "x.mix",   64'h0002_0000_0000_0000, 64'h0001_0000_0000_FFFF, 1'b1, F_GT, 4);
        run(1, "x.c0_u",  64'h2, 64'h1, 1'b1, F_GT, 4);
        run(1, "x.eq",    64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, F_EQ, 4);

        // Single-chunk instance.
        run(2, "w.s",     64'h8000_0000, 64'h1, 1'b0, F_LT, 1);
        run(2, "w.u",     64'h8000_0000, 64'h1, 1'b1, F_GT, 1);
        run(2, "w.eq",    64'h7, 64'h7, 1'b0, F_EQ, 1);

        // Backpressure: result held, new request ignored until consumed.
        set_rdy(0, 1'b0);
        issue(0, "bp", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, F_EQ, 4);
        wait_result(0);
        drive(0, 1'b1, 64'h1, 64'h2, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp.hold%0d", i), 64'(outs(0)), 64'b10100);
        end
        set_rdy(0, 1'b1);
        begin
            exp_t e;
            e.flags = F_LT; e.lat = 4; e.tag = "bp.next";
            sb.push_back(e);
        end
        @(negedge clk);
        check("bp.consumed", 64'(outs(0)), 64'b01000);
        @(negedge clk);
        drive(0, 1'b0, 64'd0, 64'd0, 1'b0);
        check("bp.accept", 64'(outs(0)[4:3]), 64'b00);
        wait_result(0);
        consume(0, "bp.next");

        // Reset two cycles into a 4-chunk compare.
        issue(0, "rst", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, F_EQ, 4);
        sb.delete();
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("rst.async", 64'({outs(0)[4], outs(0)[2:0]}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst.idle", 64'(outs(0)), 64'b01000);
        run(0, "rst.five", 64'd5, 64'd5, 1'b1, F_EQ, 4);

        // Reset while a result is being held.
        set_rdy(0, 1'b0);
        issue(0, "rst2", 64'd9, 64'd3, 1'b1, F_GT, 4);
        wait_result(0);
        #2 rst_n = 1'b0;
        #1 check("rst2.async", 64'({outs(0)[4], outs(0)[2:0]}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        set_rdy(0, 1'b1);
        @(negedge clk);
        check("rst2.idle", 64'(outs(0)), 64'b01000);
        run(0, "rst2.after", 64'h0, 64'hFFFF_0000_0000_0000, 1'b0, F_GT, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
